// File: rtl/thor2023_mem_req_arbiter_pkg.sv
// Shared types for the Thor2023 memory request front end: the request payload
// carried into the queue and the per-channel arbiter state encoding.
package Thor2023Pkg;

  localparam int NTHREADS = 4;
  localparam int THREAD_W = $clog2(NTHREADS);

  typedef struct packed {
    logic [THREAD_W-1:0] thread;
    logic [5:0]          op;
    logic [31:0]         adr;
  } memory_arg_t;

  typedef enum logic [1:0] {
    MRA_IDLE  = 2'd0,
    MRA_ISSUE = 2'd1,
    MRA_WAIT  = 2'd2
  } mra_state_t;

  // Both channels may time out in the same cycle, so the increment is 0..2.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/thor2023_mem_req_arbiter_rr_sel.sv
// Combinational round-robin finder: first set bit of eligible strictly after
// ptr, wrapping around; returns it one-hot and as an index.
module Thor2023_rr_sel #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    int  k;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    k      = 0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!found && eligible[k]) begin
        found     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/thor2023_mem_req_arbiter.sv
// Shares the memory queue's two write ports among NREQ requesters: per-channel
// issue/wait/retry FSMs with round-robin grant and rollback abandonment.
module thor2023_mem_req_arbiter
  import Thor2023Pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  memory_arg_t         arg [NREQ],
  output logic [NREQ-1:0]     ack,
  output logic                wr0,
  output logic                wr1,
  output memory_arg_t         i0,
  output memory_arg_t         i1,
  input  logic                wr_ack0,
  input  logic                wr_ack1,
  input  logic                full,
  input  logic [NTHREADS-1:0] rollback,
  output logic [15:0]         retry_cnt
);

  localparam int IW = $clog2(NREQ);
  // The timeout window opens at the strobe itself, so a retry strobe lands
  // TIMEOUT cycles after the previous one.
  localparam logic [3:0] TMO_LIM = 4'(TIMEOUT - 1);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [15:0]        retry_cnt_q, retry_cnt_d;

  logic [NREQ-1:0]    base_elig, elig0, elig1, oh0, oh1;
  logic [IW-1:0]      idx0, idx1;
  logic               grant0, grant1;

  logic [1:0]         ch_issue, ch_wr, ch_busy, ch_done, ch_retry, grant_v, ch_ack_in;
  logic [1:0][IW-1:0] ch_owner, gidx_v;
  memory_arg_t        ch_i [2];

  // A requester whose ack is pulsing this cycle still shows req, so it is
  // excluded to avoid a duplicate grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign base_elig[gi] = req[gi] && !ack_q[gi] && !rollback[arg[gi].thread]
                        && !(ch_busy[0] && ch_owner[0] == IW'(gi))
                        && !(ch_busy[1] && ch_owner[1] == IW'(gi));
    assign ack_d[gi] = (ch_done[0] && ch_owner[0] == IW'(gi))
                    || (ch_done[1] && ch_owner[1] == IW'(gi));
  end

  assign elig0 = ch_busy[0] ? '0 : base_elig;
  assign elig1 = ch_busy[1] ? '0 : (base_elig & ~oh0);

  Thor2023_rr_sel #(.N(NREQ), .IW(IW)) u_sel0 (.eligible(elig0), .ptr(rr_ptr_q), .onehot(oh0), .idx(idx0));
  Thor2023_rr_sel #(.N(NREQ), .IW(IW)) u_sel1 (.eligible(elig1), .ptr(rr_ptr_q), .onehot(oh1), .idx(idx1));

  assign grant0    = |oh0;
  assign grant1    = |oh1;
  assign grant_v   = {grant1, grant0};
  assign gidx_v[0] = idx0;
  assign gidx_v[1] = idx1;
  assign ch_ack_in = {wr_ack1, wr_ack0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    mra_state_t  state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    memory_arg_t a_q, a_d, ih_q, ih_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic        gate, rb, done, retry;

    // Channel 1 yields the write port whenever channel 0 strobes.
    if (gi == 0) begin : g_gate0
      assign gate = 1'b0;
    end else begin : g_gate1
      assign gate = ch_issue[0] && !full;
    end

    assign ch_issue[gi] = (state_q == MRA_ISSUE);
    assign ch_wr[gi]    = ch_issue[gi] && !full && !gate;
    assign ch_busy[gi]  = (state_q != MRA_IDLE);
    assign ch_owner[gi] = owner_q;
    assign ch_i[gi]     = ch_wr[gi] ? a_q : ih_q;
    assign ch_done[gi]  = done;
    assign ch_retry[gi] = retry;
    assign rb           = rollback[a_q.thread];
    assign ih_d         = ch_i[gi];

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      a_d     = a_q;
      tcnt_d  = tcnt_q;
      done    = 1'b0;
      retry   = 1'b0;
      case (state_q)
        MRA_IDLE: begin
          if (grant_v[gi]) begin
            state_d = MRA_ISSUE;
            owner_d = gidx_v[gi];
            a_d     = arg[gidx_v[gi]];
          end
        end
        MRA_ISSUE: begin
          if (rb) begin
            state_d = MRA_IDLE;
          end else if (ch_wr[gi]) begin
            state_d = MRA_WAIT;
            tcnt_d  = '0;
          end
        end
        MRA_WAIT: begin
          if (rb) begin
            state_d = MRA_IDLE;
          end else if (ch_ack_in[gi]) begin
            state_d = MRA_IDLE;
            done    = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_d >= TMO_LIM) begin
              state_d = MRA_ISSUE;
              retry   = 1'b1;
            end
          end
        end
        default: state_d = MRA_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= MRA_IDLE;
        owner_q <= '0;
        a_q     <= '0;
        ih_q    <= '0;
        tcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        a_q     <= a_d;
        ih_q    <= ih_d;
        tcnt_q  <= tcnt_d;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = grant1 ? idx1 : (grant0 ? idx0 : rr_ptr_q);
    retry_cnt_d = sat_inc16(retry_cnt_q, 2'(ch_retry[0]) + 2'(ch_retry[1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IW'(NREQ - 1);
      ack_q       <= '0;
      retry_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign ack       = ack_q;
  assign wr0       = ch_wr[0];
  assign wr1       = ch_wr[1];
  assign i0        = ch_i[0];
  assign i1        = ch_i[1];
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_thor2023_mem_req_arbiter.sv
// Scenario bench for the memory request arbiter: ack pulses are checked against
// a scoreboard filled when the bench returns queue acks.
module tb_thor2023_mem_req_arbiter;
  import Thor2023Pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req = '0;
  memory_arg_t         arg [NREQ];
  logic [NREQ-1:0]     ack;
  logic                wr0, wr1;
  memory_arg_t         i0, i1;
  logic                wr_ack0 = 1'b0, wr_ack1 = 1'b0, full = 1'b0;
  logic [NTHREADS-1:0] rollback = '0;
  logic [15:0]         retry_cnt;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t            ack_exp[$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_pass = 0;
  logic [NREQ-1:0] last_ack = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thor2023_mem_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .arg(arg), .ack(ack),
    .wr0(wr0), .wr1(wr1), .i0(i0), .i1(i1),
    .wr_ack0(wr_ack0), .wr_ack1(wr_ack1), .full(full),
    .rollback(rollback), .retry_cnt(retry_cnt)
  );

  // Ack scoreboard and write-port exclusion, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] oh;
    last_ack = ack;
    if (wr0 || wr1) begin
      n_checks++;
      if (wr0 && wr1) $display("FAIL wr_exclusive: wr0=%b wr1=%b at cycle %0d, required never both", wr0, wr1, cyc);
      else n_pass++;
    end
    if (ack !== '0) begin
      n_checks++;
      if (ack_exp.size() == 0) begin
        $display("FAIL ack_unexpected: ack=%b at cycle %0d, required none", ack, cyc);
      end else begin
        e  = ack_exp.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        if (ack !== oh || cyc != e.cyc)
          $display("FAIL ack_scoreboard: ack=%b at cycle %0d, required %b at cycle %0d", ack, cyc, oh, e.cyc);
        else begin
          n_pass++;
          $display("ack requester %0d at cycle %0d", e.idx, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0; wr_ack0 = 1'b0; wr_ack1 = 1'b0; full = 1'b0; rollback = '0;
    ack_exp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (ack_exp.size() != 0) $display("FAIL %s_drained: %0d acks outstanding, required 0", name, ack_exp.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (wr0 !== 1'b0 || wr1 !== 1'b0) $display("FAIL reset_wr: wr0=%b wr1=%b, required 0 0", wr0, wr1); else n_pass++;
    n_checks++; if (i0 !== '0) $display("FAIL reset_i0: got %h, required 0", i0); else n_pass++;
    n_checks++; if (i1 !== '0) $display("FAIL reset_i1: got %h, required 0", i1); else n_pass++;
    n_checks++; if (ack !== '0) $display("FAIL reset_ack: got %b, required 0", ack); else n_pass++;
    n_checks++; if (retry_cnt !== 16'd0) $display("FAIL reset_retry: got %0d, required 0", retry_cnt); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cyc_begin();
      req = req & ~last_ack;
      if (c == 0) req[2] = 1'b1;
      wr_ack0 = (c == 2);
      if (c == 2) ack_exp.push_back('{idx: 2, cyc: cyc + 1});
      @(negedge clk);
      n_checks++; if (wr0 !== (c == 1)) $display("FAIL single_wr0: c%0d got %b, required %b", c, wr0, c == 1); else n_pass++;
      if (c == 1) begin
        n_checks++; if (i0 !== arg[2]) $display("FAIL single_i0: got %h, required %h", i0, arg[2]); else n_pass++;
      end
      n_checks++; if (ack !== ((c == 3) ? 4'b0100 : 4'b0000)) $display("FAIL single_ack: c%0d got %b", c, ack); else n_pass++;
    end
    n_checks++; if (i0 !== arg[2]) $display("FAIL single_i0_hold: got %h, required %h", i0, arg[2]); else n_pass++;
    check_drained("single");
  endtask

  task automatic test_contention();
    exp_t exp0[$];
    exp_t exp1[$];
    exp_t e;
    logic p0, p1;
    logic [NREQ-1:0] served;
    int base;
    p0 = 1'b0; p1 = 1'b0; served = '0; base = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc_begin();
      if (c == 0) begin
        base = cyc;
        exp0.push_back('{idx: 0, cyc: base + 1}); exp0.push_back('{idx: 2, cyc: base + 4});
        exp1.push_back('{idx: 1, cyc: base + 2}); exp1.push_back('{idx: 3, cyc: base + 5});
      end
      req = req & ~last_ack;
      if (c == 0) req = 4'b1111;
      wr_ack0 = p0;
      wr_ack1 = p1;
      @(negedge clk);
      p0 = wr0;
      p1 = wr1;
      served |= ack;
      if (wr0) begin
        n_checks++;
        if (exp0.size() == 0) $display("FAIL cont_wr0_extra: strobe at cycle %0d, required none", cyc - base);
        else begin
          e = exp0.pop_front();
          if (i0 !== arg[e.idx] || cyc != e.cyc)
            $display("FAIL cont_wr0: i0=%h at c%0d, required %h at c%0d", i0, cyc - base, arg[e.idx], e.cyc - base);
          else n_pass++;
          ack_exp.push_back('{idx: e.idx, cyc: cyc + 2});
        end
      end
      if (wr1) begin
        n_checks++;
        if (exp1.size() == 0) $display("FAIL cont_wr1_extra: strobe at cycle %0d, required none", cyc - base);
        else begin
          e = exp1.pop_front();
          if (i1 !== arg[e.idx] || cyc != e.cyc)
            $display("FAIL cont_wr1: i1=%h at c%0d, required %h at c%0d", i1, cyc - base, arg[e.idx], e.cyc - base);
          else n_pass++;
          ack_exp.push_back('{idx: e.idx, cyc: cyc + 2});
        end
      end
    end
    n_checks++; if (exp0.size() + exp1.size() != 0) $display("FAIL cont_missing: %0d strobes not seen, required 0", exp0.size() + exp1.size()); else n_pass++;
    n_checks++; if (served !== 4'b1111) $display("FAIL cont_served: got %b, required 1111", served); else n_pass++;
    check_drained("cont");
  endtask

  task automatic test_dropped();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      cyc_begin();
      req = req & ~last_ack;
      if (c == 0) req = 4'b0011;
      wr_ack0 = (c == 2);
      wr_ack1 = (c == 7);
      if (c == 2) ack_exp.push_back('{idx: 0, cyc: cyc + 1});
      if (c == 7) ack_exp.push_back('{idx: 1, cyc: cyc + 1});
      @(negedge clk);
      n_checks++; if (wr0 !== (c == 1)) $display("FAIL drop_wr0: c%0d got %b", c, wr0); else n_pass++;
      n_checks++; if (wr1 !== (c == 2 || c == 6)) $display("FAIL drop_wr1: c%0d got %b, required %b", c, wr1, c == 2 || c == 6); else n_pass++;
      n_checks++; if (retry_cnt !== ((c >= 6) ? 16'd1 : 16'd0)) $display("FAIL drop_retry_cnt: c%0d got %0d", c, retry_cnt); else n_pass++;
      if (c == 6) begin
        n_checks++; if (i1 !== arg[1]) $display("FAIL drop_i1: got %h, required %h", i1, arg[1]); else n_pass++;
      end
    end
    check_drained("drop");
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc_begin();
      req = req & ~last_ack;
      if (c == 0) req = 4'b0001;
      full = (c >= 1 && c <= 5);
      wr_ack0 = (c == 7);
      if (c == 7) ack_exp.push_back('{idx: 0, cyc: cyc + 1});
      @(negedge clk);
      n_checks++; if (wr0 !== (c == 6)) $display("FAIL full_wr0: c%0d got %b, required %b", c, wr0, c == 6); else n_pass++;
      if (c == 6) begin
        n_checks++; if (i0 !== arg[0]) $display("FAIL full_i0: got %h, required %h", i0, arg[0]); else n_pass++;
      end
    end
    full = 1'b0;
    check_drained("full");
  endtask

  task automatic test_rollback();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc_begin();
      req = req & ~last_ack;
      if (c == 0) req = 4'b0010;
      if (c == 2) req[1] = 1'b0;
      if (c == 4) req[3] = 1'b1;
      rollback = '0;
      if (c == 2) rollback[arg[1].thread] = 1'b1;
      wr_ack0 = (c == 2 || c == 6);
      if (c == 6) ack_exp.push_back('{idx: 3, cyc: cyc + 1});
      @(negedge clk);
      n_checks++; if (wr0 !== (c == 1 || c == 5)) $display("FAIL rb_wr0: c%0d got %b, required %b", c, wr0, c == 1 || c == 5); else n_pass++;
      n_checks++; if (ack !== ((c == 7) ? 4'b1000 : 4'b0000)) $display("FAIL rb_ack: c%0d got %b", c, ack); else n_pass++;
      if (c == 5) begin
        n_checks++; if (i0 !== arg[3]) $display("FAIL rb_i0: got %h, required %h", i0, arg[3]); else n_pass++;
      end
    end
    rollback = '0;
    check_drained("rb");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc_begin();
      req = req & ~last_ack;
      if (c == 0) req = 4'b0010;
      if (c == 2) begin
        rst_n = 1'b0;
        req = req | 4'b0101;
      end
      if (c == 4) rst_n = 1'b1;
      wr_ack0 = (c == 6 || c == 9);
      wr_ack1 = (c == 7);
      if (c == 6) ack_exp.push_back('{idx: 0, cyc: cyc + 1});
      if (c == 7) ack_exp.push_back('{idx: 1, cyc: cyc + 1});
      if (c == 9) ack_exp.push_back('{idx: 2, cyc: cyc + 1});
      @(negedge clk);
      if (c == 2 || c == 3) begin
        n_checks++;
        if (wr0 !== 1'b0 || wr1 !== 1'b0 || ack !== '0 || retry_cnt !== 16'd0 || i0 !== '0 || i1 !== '0)
          $display("FAIL rstmid_outputs: c%0d wr0=%b wr1=%b ack=%b retry=%0d i0=%h i1=%h, required all 0", c, wr0, wr1, ack, retry_cnt, i0, i1);
        else n_pass++;
      end
      n_checks++; if (wr0 !== (c == 1 || c == 5 || c == 8)) $display("FAIL rstmid_wr0: c%0d got %b", c, wr0); else n_pass++;
      n_checks++; if (wr1 !== (c == 6)) $display("FAIL rstmid_wr1: c%0d got %b", c, wr1); else n_pass++;
      if (c == 5) begin
        n_checks++; if (i0 !== arg[0]) $display("FAIL rstmid_regrant_i0: got %h, required %h", i0, arg[0]); else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (i1 !== arg[1]) $display("FAIL rstmid_regrant_i1: got %h, required %h", i1, arg[1]); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (i0 !== arg[2]) $display("FAIL rstmid_i0_next: got %h, required %h", i0, arg[2]); else n_pass++;
      end
    end
    check_drained("rstmid");
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      arg[k].thread = THREAD_W'(k);
      arg[k].op     = 6'(k + 1);
      arg[k].adr    = 32'hA000_0000 + 32'(k * 16);
    end
    test_reset();
    test_single();
    test_contention();
    test_dropped();
    test_full();
    test_rollback();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
